// File: rtl/input_buffer.sv
// Eight-entry flit FIFO with registered read data and exposed storage pointers.
// A pop frees a slot in the same cycle, so a full buffer accepts a write alongside a pop.
module input_buffer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         buf_data_i,
    input  logic                     buf_write_i,
    input  logic                     buf_read_i,
    output logic                     buf_empty_o,
    output logic                     bup_valid_o,
    output logic [WIDTH-1:0]         buf_data_o,
    output logic [$clog2(DEPTH)-1:0] buf_ram_raddr_o,
    output logic [$clog2(DEPTH)-1:0] buf_ram_waddr_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    raddr_q, raddr_d;
    logic [AW-1:0]    waddr_q, waddr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             pop_ok;
    logic             push_ok;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
    endfunction

    assign pop_ok  = buf_read_i && (count_q != '0);
    assign push_ok = buf_write_i && ((count_q != CW'(DEPTH)) || pop_ok);

    always_comb begin
        count_d = count_q;
        raddr_d = raddr_q;
        waddr_d = waddr_q;
        data_d  = data_q;
        valid_d = 1'b0;
        if (pop_ok) begin
            data_d  = mem_q[raddr_q];
            valid_d = 1'b1;
            raddr_d = ptr_inc(raddr_q);
        end
        if (push_ok) begin
            waddr_d = ptr_inc(waddr_q);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            raddr_q <= '0;
            waddr_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // Storage is deliberately left out of reset; stale contents are never readable.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem_q[waddr_q] <= buf_data_i;
        end
    end

    assign buf_empty_o     = (count_q == '0);
    assign bup_valid_o     = valid_q;
    assign buf_data_o      = data_q;
    assign buf_ram_raddr_o = raddr_q;
    assign buf_ram_waddr_o = waddr_q;

endmodule

// File: tb/tb_input_buffer.sv
// Bench for input_buffer: directed scenarios plus random traffic, checked against a queue model.
module tb_input_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] buf_data_i;
    logic        buf_write_i;
    logic        buf_read_i;
    logic        buf_empty_o;
    logic        bup_valid_o;
    logic [15:0] buf_data_o;
    logic [2:0]  buf_ram_raddr_o;
    logic [2:0]  buf_ram_waddr_o;

    int checks = 0;
    int errors = 0;

    logic [15:0] model_q[$];
    int          n_push;
    int          n_pop;
    logic [15:0] exp_data;
    logic        exp_valid;

    input_buffer #(.DEPTH(8), .WIDTH(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .buf_data_i      (buf_data_i),
        .buf_write_i     (buf_write_i),
        .buf_read_i      (buf_read_i),
        .buf_empty_o     (buf_empty_o),
        .bup_valid_o     (bup_valid_o),
        .buf_data_o      (buf_data_o),
        .buf_ram_raddr_o (buf_ram_raddr_o),
        .buf_ram_waddr_o (buf_ram_waddr_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, update the queue model, compare every output.
    task automatic step(input logic w, input logic r, input logic [15:0] d, input logic rst);
        logic pop, push;
        buf_write_i = w;
        buf_read_i  = r;
        buf_data_i  = d;
        reset       = rst;
        @(posedge clk);
        if (rst) begin
            model_q.delete();
            n_push    = 0;
            n_pop     = 0;
            exp_data  = 16'h0000;
            exp_valid = 1'b0;
        end else begin
            pop  = r && (model_q.size() > 0);
            push = w && ((model_q.size() < 8) || pop);
            exp_valid = pop;
            if (pop) begin
                exp_data = model_q.pop_front();
                n_pop++;
            end
            if (push) begin
                model_q.push_back(d);
                n_push++;
            end
        end
        #1;
        check("empty", 32'(buf_empty_o), 32'(model_q.size() == 0));
        check("valid", 32'(bup_valid_o), 32'(exp_valid));
        check("data",  32'(buf_data_o),  32'(exp_data));
        check("raddr", 32'(buf_ram_raddr_o), 32'(n_pop % 8));
        check("waddr", 32'(buf_ram_waddr_o), 32'(n_push % 8));
    endtask

    initial begin
        buf_write_i = 1'b0;
        buf_read_i  = 1'b0;
        buf_data_i  = 16'h0;
        reset       = 1'b1;
        n_push = 0;
        n_pop  = 0;
        exp_data  = 16'h0;
        exp_valid = 1'b0;

        // Reset state, then a lone write
        step(1'b1, 1'b1, 16'h1234, 1'b1);
        check("rst_empty", 32'(buf_empty_o), 32'd1);
        step(1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 16'h8000, 1'b0);
        check("w1_waddr", 32'(buf_ram_waddr_o), 32'd1);
        check("w1_empty", 32'(buf_empty_o), 32'd0);
        check("w1_valid", 32'(bup_valid_o), 32'd0);

        // Read with continued writes: first pop returns 8000
        step(1'b1, 1'b1, 16'h8001, 1'b0);
        check("rw_valid", 32'(bup_valid_o), 32'd1);
        check("rw_data",  32'(buf_data_o), 32'h8000);
        check("rw_raddr", 32'(buf_ram_raddr_o), 32'd1);
        step(1'b1, 1'b1, 16'h8002, 1'b0);
        check("rw_data2", 32'(buf_data_o), 32'h8001);

        // Read while empty after reset
        step(1'b0, 1'b0, 16'h0, 1'b1);
        step(1'b0, 1'b1, 16'h0, 1'b0);
        check("re_valid", 32'(bup_valid_o), 32'd0);
        check("re_data",  32'(buf_data_o), 32'h0);
        check("re_raddr", 32'(buf_ram_raddr_o), 32'd0);

        // Write+read while empty: write only, data poppable next cycle
        step(1'b1, 1'b1, 16'h5A5A, 1'b0);
        check("we_valid", 32'(bup_valid_o), 32'd0);
        step(1'b0, 1'b1, 16'h0, 1'b0);
        check("we_data",  32'(buf_data_o), 32'h5A5A);

        // Fill to 8, drop the ninth, drain in order
        step(1'b0, 1'b0, 16'h0, 1'b1);
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 16'(i), 1'b0);
        step(1'b1, 1'b0, 16'hFFFF, 1'b0);
        check("full_waddr", 32'(buf_ram_waddr_o), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, 16'h0, 1'b0);
            check("drain_data", 32'(buf_data_o), 32'(i));
        end
        check("drain_empty", 32'(buf_empty_o), 32'd1);

        // Full plus simultaneous push/pop keeps the buffer full
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'hB000 + 16'(i), 1'b0);
        step(1'b1, 1'b1, 16'hB0FF, 1'b0);
        check("fullrw_data", 32'(buf_data_o), 32'hB000);

        // Interleaved push/pop of 10 flits wraps both pointers
        step(1'b0, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 16'hA000 + 16'(i), 1'b0);
            step(1'b0, 1'b1, 16'h0, 1'b0);
            check("wrap_data", 32'(buf_data_o), 32'(16'hA000 + 16'(i)));
        end
        check("wrap_raddr", 32'(buf_ram_raddr_o), 32'd2);
        check("wrap_waddr", 32'(buf_ram_waddr_o), 32'd2);

        // Mid-operation reset discards queued entries
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'hC000 + 16'(i), 1'b0);
        step(1'b1, 1'b1, 16'hDEAD, 1'b1);
        check("mrst_empty", 32'(buf_empty_o), 32'd1);
        check("mrst_raddr", 32'(buf_ram_raddr_o), 32'd0);
        check("mrst_waddr", 32'(buf_ram_waddr_o), 32'd0);
        step(1'b1, 1'b0, 16'h7777, 1'b0);
        step(1'b0, 1'b1, 16'h0, 1'b0);
        check("mrst_pop", 32'(buf_data_o), 32'h7777);

        // Random traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
                 16'($urandom), 1'($urandom_range(0, 199) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_buffer.md
INPUT_BUFFER -- requirements
Module: input_buffer

Interface
REQ-001 The block SHALL have the parameter DEPTH, default 8, meaning the number of FIFO entries; 8 is the only required value.
REQ-002 The block SHALL have the parameter WIDTH, default 16, meaning the flit data width in bits.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port buf_data_i, input, 16 bits: flit to be written.
REQ-006 Port buf_write_i, input, 1 bit: write request; the flit is sampled on the same edge.
REQ-007 Port buf_read_i, input, 1 bit: read (pop) request.
REQ-008 Port buf_empty_o, output, 1 bit: high when the buffer holds zero entries.
REQ-009 Port bup_valid_o, output, 1 bit: high for the cycle after a successful pop, qualifying buf_data_o; the port name is spelled exactly so.
REQ-010 Port buf_data_o, output, 16 bits: registered read data.
REQ-011 Port buf_ram_raddr_o, output, 3 bits: current read pointer, i.e. the storage index of the oldest entry.
REQ-012 Port buf_ram_waddr_o, output, 3 bits: current write pointer, i.e. the index of the next free slot.

Function
REQ-013 Storage SHALL be an 8 x 16-bit register array with in-order (FIFO) delivery.
REQ-014 An occupancy counter of 4 bits, range 0..8, SHALL track fill level; full means count==8, and full is internal only.
REQ-015 A write is accepted when buf_write_i=1 and (count<8, or a pop is accepted in the same cycle); it stores buf_data_i at waddr, and waddr increments modulo 8.
REQ-016 A write while full with no simultaneous pop SHALL be dropped; no state changes.
REQ-017 A pop is accepted when buf_read_i=1 and count>0 at the start of the cycle.
REQ-018 An accepted pop SHALL register mem[raddr] into buf_data_o, set bup_valid_o=1 on the next cycle, and increment raddr modulo 8.
REQ-019 Read latency SHALL be one clock: data is valid in the cycle after buf_read_i is sampled.
REQ-020 A read while empty SHALL be ignored: bup_valid_o=0, buf_data_o holds its value, and raddr is unchanged.
REQ-021 A simultaneous accepted write and pop SHALL leave count unchanged while both pointers advance.
REQ-022 A write and a read in the same cycle while empty SHALL perform the write only; there is no bypass, and the data becomes poppable the next cycle.
REQ-023 bup_valid_o SHALL be 0 in any cycle not following an accepted pop.
REQ-024 buf_empty_o SHALL be decoded combinationally from count==0.
REQ-025 Both pointers SHALL wrap from 7 to 0 with no other effect.
REQ-026 Asserting reset SHALL have priority over simultaneous read and write.

Reset
REQ-027 On a rising clk edge with reset=1, the block SHALL set count=0, raddr=0, waddr=0, buf_data_o=16'h0000 and bup_valid_o=0, so that buf_empty_o=1.
REQ-028 Reset SHALL leave storage contents unchanged; they are don't-care after reset.
REQ-029 Reset asserted mid-operation SHALL discard all queued entries; the first post-reset write SHALL land at address 0.

Verification
REQ-030 Reset then write 16'h8000 with no read -> buf_ram_waddr_o=1 and buf_empty_o=0, with bup_valid_o remaining 0.
REQ-031 Write 16'h8000, then hold buf_read_i=1 together with continued writes -> on the cycle after the first accepted read, bup_valid_o=1, buf_data_o=16'h8000 and buf_ram_raddr_o=1, with the occupancy staying steady.
REQ-032 Write 16'h0001..16'h0008, then a 9th write of 16'hFFFF -> the 9th write is dropped and waddr=0; eight pops return 1..8 in order, after which buf_empty_o=1.
REQ-033 Read while empty after reset -> bup_valid_o=0, buf_data_o=0 and raddr=0.
REQ-034 Push and pop 10 flits (16'hA000+i), interleaved -> both pointers wrap past 7 to 0 and data arrives in order with no loss.
REQ-035 With 3 entries queued, assert reset for one cycle -> buf_empty_o=1 and both pointers=0; the next write goes to address 0 and the next pop returns that new flit.
